uart_pulse_cmd_parser: RTL and testbench
========================================

// Module: uart_pulse_cmd_parser
// PURPOSE
//  Upstream command stage for the pulse generator. Takes bytes from uart_rx (po_data/po_flag),
//  assembles 9-byte pulse commands, and range-checks and clamps each field. It then presents
//  registered pulse_select/width/gap values with a 1-cycle cmd_valid strobe that feeds the
//  generator's trigger input. A 1-byte ack goes to uart_tx. Runs fully in the sys_clk domain;
//  po_flag is never used as a clock.
// PARAMETERS
//  HEADER       8'h07        frame header (byte 0)
//  FRAME_LEN    9            bytes per frame, header included
//  MIN_VAL      16'd4        floor applied to width1/width2/gap (units of generator ticks)
//  TIMEOUT_CYC  104_167      max sys_clk cycles between bytes inside a frame (~2 chars @9600, 50MHz)
// PORTS
//  sys_clk       in   1   system clock, 50 MHz
//  sys_rst_n     in   1   asynchronous reset, active-low
//  rx_data       in   8   received byte, valid when rx_flag=1
//  rx_flag       in   1   1-cycle byte-valid strobe from uart_rx
//  pulse_select  out  2   bit0=channel1 enable, bit1=channel2 enable
//  pulse_width1  out  16  channel-1 pulse width
//  pulse_width2  out  16  channel-2 pulse width
//  pulse_gap     out  16  gap between channel pulses
//  cmd_valid     out  1   1-cycle strobe: new command committed, fire pulses
//  ack_data      out  8   {6'b0, pulse_select} of last committed command
//  ack_flag      out  1   1-cycle strobe to uart_tx pi_flag
//  frame_err     out  1   1-cycle strobe: frame dropped by inter-byte timeout
// BEHAVIOUR
//  Reset: pulse_select=0, width1=width2=gap=5, ack_data=0, and all strobes=0. State goes to IDLE
//   and the byte counter and timeout counter clear. Reset mid-frame discards the partial frame.
//  Frame layout: byte0=HEADER, byte1=ch1 enable, byte2=ch2 enable, and bytes 3-4, 5-6 and 7-8
//   hold width1, width2 and gap. Each 16-bit field is big-endian (high byte first).
//  FSM IDLE:
//   - rx_flag with rx_data==HEADER moves to RECV with byte count = 1.
//   - Any other byte is silently discarded and no error is raised.
//  FSM RECV:
//   - Each rx_flag stores the byte in its shadow register and increments the count.
//   - The timeout counter clears on every rx_flag and otherwise increments.
//   - Timeout counter reaching TIMEOUT_CYC returns to IDLE and pulses frame_err. Shadow
//     registers and outputs are left unchanged.
//   - The rx_flag carrying byte FRAME_LEN-1 moves to COMMIT.
//  FSM COMMIT, one cycle, then IDLE:
//   - Output registers load from the shadow registers and cmd_valid=1 for exactly this cycle.
//   - Outputs are stable and valid in the same cycle cmd_valid is high.
//   - Each 16-bit field below MIN_VAL is replaced by MIN_VAL (compare is unsigned, 16-bit).
//   - pulse_select = {byte2==8'h01, byte1==8'h01}. Any other value disables that channel.
//  Latency: last byte rx_flag at cycle N gives outputs plus cmd_valid at N+1. At N+2,
//   ack_flag=1 with ack_data={6'b0,new pulse_select}.
//  rx_flag during COMMIT is handled with IDLE rules, so a HEADER byte starts a new frame and no
//   byte is lost. At UART rates this cannot occur in practice, but the RTL must still handle it.
//  Outputs hold their value between commands. The generator samples them on cmd_valid.
//  Header value inside the payload has no special meaning. Resync happens only via timeout or
//   frame completion.
// TESTING
//  1. Reset, then send 07 01 00 00 64 00 0A 00 32 with 1 char gaps -> one cmd_valid. Result:
//     sel=2'b01, w1=100, w2=10, gap=50. Next cycle ack_flag=1, ack_data=8'h01.
//  2. Send 07 01 01 00 02 00 00 00 03 -> w1=4, w2=4, gap=4 (clamped), sel=2'b11, ack_data=8'h03.
//  3. Send AA 55 then the frame from test 1 -> leading bytes ignored, exactly one cmd_valid,
//     and values match test 1.
//  4. Send 07 01 00 00 then idle for TIMEOUT_CYC+10 cycles -> frame_err once, no cmd_valid,
//     outputs unchanged. Then send a full frame -> accepted normally.
//  5. Assert sys_rst_n=0 after byte 5 of a frame, release, then send a full frame ->
//     outputs show reset values (5/5/5, sel=0) until the new frame's cmd_valid.
//  6. Send two frames back-to-back with zero idle between them -> two cmd_valid and two
//     ack_flag strobes, with the second frame's values ending up on the outputs.

Source files
------------

// File: rtl/uart_pulse_cmd_parser.sv
// Assembles 9-byte pulse commands from uart_rx bytes, clamps the 16-bit fields, and
// presents them with a cmd_valid strobe, followed one cycle later by an ack byte for uart_tx.
module uart_pulse_cmd_parser #(
    parameter logic [7:0]  HEADER      = 8'h07,
    parameter int          FRAME_LEN   = 9,
    parameter logic [15:0] MIN_VAL     = 16'd4,
    parameter int          TIMEOUT_CYC = 104_167
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    output logic [1:0]  pulse_select,
    output logic [15:0] pulse_width1,
    output logic [15:0] pulse_width2,
    output logic [15:0] pulse_gap,
    output logic        cmd_valid,
    output logic [7:0]  ack_data,
    output logic        ack_flag,
    output logic        frame_err
);

    localparam int               CNT_W    = $clog2(FRAME_LEN);
    localparam int               TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]      RST_VAL  = 16'd5;

    typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [TO_W-1:0]  tcnt_reg, tcnt_next;
    logic             store_byte, load_cmd, timeout_hit;

    logic [1:0]  pulse_select_reg;
    logic [15:0] pulse_width1_reg, pulse_width2_reg, pulse_gap_reg;
    logic        cmd_valid_reg, ack_flag_reg, frame_err_reg;
    logic [7:0]  ack_data_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tcnt_reg  <= tcnt_next;
        end
    end

    // COMMIT behaves like IDLE for incoming bytes so a header arriving there is not lost.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        tcnt_next   = tcnt_reg;
        store_byte  = 1'b0;
        load_cmd    = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            RECV: begin
                if (rx_flag) begin
                    tcnt_next = '0;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_IDX) begin
                        state_next = COMMIT;
                        load_cmd   = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        store_byte = 1'b1;
                    end
                end else if (tcnt_reg == TO_LAST) begin
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
                    tcnt_next   = '0;
                    cnt_next    = '0;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                tcnt_next  = '0;
                if (rx_flag && rx_data == HEADER) begin
                    state_next = RECV;
                    cnt_next   = CNT_W'(1);
                end
            end
        endcase
    end

    // Payload bytes 1..FRAME_LEN-2; the final byte is taken straight from rx_data on commit.
    genvar gi;
    generate
        for (gi = 1; gi <= FRAME_LEN - 2; gi++) begin : g_shadow
            logic [7:0] byte_reg;
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n)
                    byte_reg <= '0;
                else if (store_byte && cnt_reg == CNT_W'(gi))
                    byte_reg <= rx_data;
            end
        end
    endgenerate

    function automatic logic [15:0] clamp(input logic [15:0] v);
        return (v < MIN_VAL) ? MIN_VAL : v;
    endfunction

    logic [15:0] w1_raw, w2_raw, gap_raw;
    logic [1:0]  sel_raw;
    assign w1_raw  = {g_shadow[3].byte_reg, g_shadow[4].byte_reg};
    assign w2_raw  = {g_shadow[5].byte_reg, g_shadow[6].byte_reg};
    assign gap_raw = {g_shadow[7].byte_reg, rx_data};
    assign sel_raw = {g_shadow[2].byte_reg == 8'h01, g_shadow[1].byte_reg == 8'h01};

    // Outputs load on the edge that takes the last byte, so they are valid alongside cmd_valid.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pulse_select_reg <= '0;
            pulse_width1_reg <= RST_VAL;
            pulse_width2_reg <= RST_VAL;
            pulse_gap_reg    <= RST_VAL;
            cmd_valid_reg    <= 1'b0;
            ack_flag_reg     <= 1'b0;
            ack_data_reg     <= '0;
            frame_err_reg    <= 1'b0;
        end else begin
            cmd_valid_reg <= load_cmd;
            ack_flag_reg  <= cmd_valid_reg;
            frame_err_reg <= timeout_hit;
            if (load_cmd) begin
                pulse_select_reg <= sel_raw;
                pulse_width1_reg <= clamp(w1_raw);
                pulse_width2_reg <= clamp(w2_raw);
                pulse_gap_reg    <= clamp(gap_raw);
            end
            if (cmd_valid_reg)
                ack_data_reg <= {6'b0, pulse_select_reg};
        end
    end

    assign pulse_select = pulse_select_reg;
    assign pulse_width1 = pulse_width1_reg;
    assign pulse_width2 = pulse_width2_reg;
    assign pulse_gap    = pulse_gap_reg;
    assign cmd_valid    = cmd_valid_reg;
    assign ack_data     = ack_data_reg;
    assign ack_flag     = ack_flag_reg;
    assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_uart_pulse_cmd_parser.sv
// Directed bench for uart_pulse_cmd_parser: table of frames plus hand-written
// latency, timeout, mid-frame reset and back-to-back sequences.
module tb_uart_pulse_cmd_parser;

    localparam int TO  = 300;
    localparam int GAP = 20;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_flag = 1'b0;
    logic [1:0]  pulse_select;
    logic [15:0] pulse_width1, pulse_width2, pulse_gap;
    logic        cmd_valid, ack_flag, frame_err;
    logic [7:0]  ack_data;

    uart_pulse_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx_data      (rx_data),
        .rx_flag      (rx_flag),
        .pulse_select (pulse_select),
        .pulse_width1 (pulse_width1),
        .pulse_width2 (pulse_width2),
        .pulse_gap    (pulse_gap),
        .cmd_valid    (cmd_valid),
        .ack_data     (ack_data),
        .ack_flag     (ack_flag),
        .frame_err    (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmd = 0, n_ack = 0, n_err = 0;
    always @(negedge sys_clk) begin
        if (cmd_valid) n_cmd++;
        if (ack_flag)  n_ack++;
        if (frame_err) n_err++;
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge sys_clk);
            #1;
        end
    endtask

    // Called 1 time unit after an edge; returns 1 time unit after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_flag = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_flag = 1'b0;
    endtask

    task automatic send_frame(input logic [71:0] f, input int gap);
        for (int i = 0; i < 9; i++) begin
            send_byte(f[71-8*i -: 8]);
            if (i < 8) idle(gap);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] sel, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] gp);
        check({tag, ".sel"}, 32'(pulse_select), 32'(sel));
        check({tag, ".w1"},  32'(pulse_width1), 32'(w1));
        check({tag, ".w2"},  32'(pulse_width2), 32'(w2));
        check({tag, ".gap"}, 32'(pulse_gap),    32'(gp));
    endtask

    typedef struct {
        logic        lead;
        logic [71:0] frame;
        logic [1:0]  sel;
        logic [15:0] w1, w2, gap;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int c0, a0, e0;
        logic [71:0] f1;

        vecs[0] = '{1'b0, 72'h07_01_00_0064_000A_0032, 2'b01, 16'd100, 16'd10, 16'd50};
        vecs[1] = '{1'b0, 72'h07_01_01_0002_0000_0003, 2'b11, 16'd4,   16'd4,  16'd4};
        vecs[2] = '{1'b0, 72'h07_02_FF_0004_0003_FFFF, 2'b00, 16'd4,   16'd4,  16'hFFFF};
        vecs[3] = '{1'b0, 72'h07_07_01_0107_0007_0700, 2'b10, 16'h0107, 16'd7, 16'h0700};
        vecs[4] = '{1'b1, 72'h07_01_00_0064_000A_0032, 2'b01, 16'd100, 16'd10, 16'd50};

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check_outs("reset", 2'b00, 16'd5, 16'd5, 16'd5);
        check("reset.ack_data", 32'(ack_data), 32'h0);
        check("reset.strobes", 32'({cmd_valid, ack_flag, frame_err}), 32'h0);
        sys_rst_n = 1'b1;
        idle(2);

        // Exact latency of commit and ack for the first command
        f1 = vecs[0].frame;
        c0 = n_cmd;
        for (int i = 0; i < 8; i++) begin
            send_byte(f1[71-8*i -: 8]);
            idle(GAP);
        end
        check("lat.pre_valid", 32'(cmd_valid), 32'h0);
        send_byte(f1[7:0]);
        check("lat.cmd_valid_n1", 32'(cmd_valid), 32'h1);
        check("lat.ack_n1", 32'(ack_flag), 32'h0);
        check_outs("lat.n1", 2'b01, 16'd100, 16'd10, 16'd50);
        idle(1);
        check("lat.cmd_valid_n2", 32'(cmd_valid), 32'h0);
        check("lat.ack_n2", 32'(ack_flag), 32'h1);
        check("lat.ack_data_n2", 32'(ack_data), 32'h01);
        idle(1);
        check("lat.ack_n3", 32'(ack_flag), 32'h0);
        check("lat.cmd_count", 32'(n_cmd - c0), 32'd1);
        $display("latency frame: sel=%b w1=%0d w2=%0d gap=%0d ack=%02h",
                 pulse_select, pulse_width1, pulse_width2, pulse_gap, ack_data);

        // Table of frames
        for (int v = 0; v < 5; v++) begin
            c0 = n_cmd; a0 = n_ack; e0 = n_err;
            if (vecs[v].lead) begin
                send_byte(8'hAA); idle(GAP);
                send_byte(8'h55); idle(GAP);
            end
            send_frame(vecs[v].frame, GAP);
            idle(4);
            $display("vec %0d: frame=%018h sel=%b w1=%0d w2=%0d gap=%0d ack=%02h", v,
                     vecs[v].frame, pulse_select, pulse_width1, pulse_width2, pulse_gap, ack_data);
            check($sformatf("vec%0d.cmd_count", v), 32'(n_cmd - c0), 32'd1);
            check($sformatf("vec%0d.ack_count", v), 32'(n_ack - a0), 32'd1);
            check($sformatf("vec%0d.err_count", v), 32'(n_err - e0), 32'd0);
            check_outs($sformatf("vec%0d", v), vecs[v].sel, vecs[v].w1, vecs[v].w2, vecs[v].gap);
            check($sformatf("vec%0d.ack_data", v), 32'(ack_data), 32'({6'b0, vecs[v].sel}));
        end

        // Long but legal inter-byte gap is accepted
        c0 = n_cmd; e0 = n_err;
        send_byte(8'h07); idle(TO - 2);
        for (int i = 1; i < 9; i++) send_byte(vecs[1].frame[71-8*i -: 8]);
        idle(4);
        check("slowgap.cmd_count", 32'(n_cmd - c0), 32'd1);
        check("slowgap.err_count", 32'(n_err - e0), 32'd0);
        check_outs("slowgap", 2'b11, 16'd4, 16'd4, 16'd4);
        $display("slow gap frame: sel=%b w1=%0d", pulse_select, pulse_width1);

        // Timeout drops a partial frame, outputs hold, next frame accepted
        c0 = n_cmd; e0 = n_err;
        send_byte(8'h07); idle(GAP);
        send_byte(8'h01); idle(GAP);
        send_byte(8'h00); idle(GAP);
        send_byte(8'h00);
        idle(TO + 10);
        check("timeout.err_count", 32'(n_err - e0), 32'd1);
        check("timeout.cmd_count", 32'(n_cmd - c0), 32'd0);
        check_outs("timeout.hold", 2'b11, 16'd4, 16'd4, 16'd4);
        send_frame(vecs[0].frame, GAP);
        idle(4);
        check("timeout.next_cmd", 32'(n_cmd - c0), 32'd1);
        check_outs("timeout.next", 2'b01, 16'd100, 16'd10, 16'd50);
        $display("timeout: frame_err=%0d then sel=%b w1=%0d", n_err - e0, pulse_select, pulse_width1);

        // Reset mid-frame restores reset values; the tail bytes are ignored
        c0 = n_cmd;
        send_byte(8'h07); idle(GAP);
        send_byte(8'h01); idle(GAP);
        send_byte(8'h01); idle(GAP);
        send_byte(8'h00); idle(GAP);
        send_byte(8'h10); idle(2);
        sys_rst_n = 1'b0;
        idle(3);
        sys_rst_n = 1'b1;
        idle(2);
        check_outs("midrst", 2'b00, 16'd5, 16'd5, 16'd5);
        check("midrst.ack_data", 32'(ack_data), 32'h0);
        send_byte(8'h20); idle(GAP);
        send_byte(8'h00); idle(GAP);
        send_byte(8'h30); idle(4);
        check("midrst.tail_cmd", 32'(n_cmd - c0), 32'd0);
        check_outs("midrst.tail", 2'b00, 16'd5, 16'd5, 16'd5);
        send_frame(vecs[3].frame, GAP);
        idle(4);
        check("midrst.new_cmd", 32'(n_cmd - c0), 32'd1);
        check_outs("midrst.new", 2'b10, 16'h0107, 16'd7, 16'h0700);
        $display("mid-frame reset: sel=%b w1=%0d", pulse_select, pulse_width1);

        // Back-to-back frames, header of second lands in the commit cycle
        c0 = n_cmd; a0 = n_ack;
        send_frame(vecs[0].frame, 0);
        send_frame(vecs[2].frame, 0);
        idle(4);
        check("b2b.cmd_count", 32'(n_cmd - c0), 32'd2);
        check("b2b.ack_count", 32'(n_ack - a0), 32'd2);
        check_outs("b2b", 2'b00, 16'd4, 16'd4, 16'hFFFF);
        check("b2b.ack_data", 32'(ack_data), 32'h00);
        $display("back-to-back: cmds=%0d sel=%b gap=%0h", n_cmd - c0, pulse_select, pulse_gap);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
